// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive framer
package uart_rx_pkg;

    // Level of an idle RX line; also the reset value of the pin synchronizer
    localparam logic LINE_IDLE = 1'b1;

    // State codes kept as plain constants so older tooling can decode the bus
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - sample/serial inputs and byte output bundle of the framer (parity_err with UART_RX_PARITY_EN)
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_tick;
    logic                 rx_serial;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    // Framer side: consumes ticks and the pin, produces bytes and error pulses
    modport master (
        input  sample_tick,
        input  rx_serial,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output overrun_err
    );

    // Consumer/driver side
    modport slave (
        output sample_tick,
        output rx_serial,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  overrun_err
    );

endinterface

// File: rtl/rx_sync_2ff.sv
// rtl/rx_sync_2ff.sv - two-flop synchronizer for an asynchronous input pin
module rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the pin through two stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Both stages reset to the inactive level of the pin
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 8N1 receive framer with glitch/framing/overrun detection; UART_RX_PARITY_EN adds even parity
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    uart_rx_frame_if.master bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Tick count at the start-bit centre and at each full bit period
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 commit;
    logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_q, parity_bit_d;
    logic                 parity_err_q, parity_err_d;
    logic                 par_bad;
`endif

    rx_sync_2ff #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (bus.rx_serial),
        .q     (rx_s)
    );

    // Frame FSM: all timing advances only on sample_tick
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        armed_d  = armed_q | rx_s;
        commit   = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        par_bad      = 1'b0;
`endif
        if (bus.sample_tick) begin
            case (state_q)
                IDLE: begin
                    // A held-low line cannot restart a frame until it has gone high
                    if (!rx_s && armed_q) begin
                        state_d = START;
                        tcnt_d  = '0;
                        armed_d = 1'b0;
                    end
                end
                START: begin
                    if (tcnt_q == T_MID) begin
                        tcnt_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bcnt_d  = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tcnt_q == T_END) begin
                        tcnt_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bcnt_q == B_LAST) begin
                            bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tcnt_q == T_END) begin
                        tcnt_d       = '0;
                        parity_bit_d = rx_s;
                        state_d      = STOP;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
`endif
                STOP: begin
                    if (tcnt_q == T_END) begin
                        tcnt_d  = '0;
                        state_d = IDLE;
                        // Framing error wins over a parity error
                        if (!rx_s) begin
                            stop_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (^{shift_q, parity_bit_q}) begin
                            par_bad = 1'b1;
`endif
                        end else begin
                            commit = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                end
            endcase
        end
    end

    // Output register: handshake drains, commits load or report overrun
    always_comb begin
        rx_valid_d    = rx_valid_q;
        rx_data_d     = rx_data_q;
        frame_err_d   = stop_bad;
        overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d  = par_bad;
`endif
        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (commit) begin
            if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end
    end

    // State and output flops; reset drops any partial frame
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tcnt_q        <= '0;
            bcnt_q        <= '0;
            armed_q       <= 1'b0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q  <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            bcnt_q        <= bcnt_d;
            armed_q       <= armed_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q  <= parity_bit_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = parity_err_q;
`endif

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receive framer for the RGB-PWM command path. Consumes the periodic sample enable from the baud-rate sampler, which is configured for OVERSAMPLE ticks per bit. Recovers asynchronous 8N1 frames from the RX pin and presents each byte on a valid/ready output register to the command decoder. Detects glitched start bits, framing errors and overruns; parity checking is optional.

## Interface
- OVERSAMPLE, 16: sample ticks per bit period; even, ≥4.
- DATA_BITS, 8: data bits per frame, LSB first.
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on sys_clk rising edge.
- sample_tick  in  1  one-cycle enable from the baud-rate sampler, OVERSAMPLE per bit.
- rx_serial  in  1  asynchronous RX pin; idle high.
- rx_data  out  DATA_BITS  received byte; reset 0.
- rx_valid  out  1  rx_data holds an unconsumed byte; reset 0.
- rx_ready  in  1  consumer accepts rx_data this cycle when rx_valid=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled low; reset 0.
- overrun_err  out  1  one-cycle pulse: good frame lost because output still full; reset 0.
- parity_err  out  1  one-cycle pulse; present only with UART_RX_PARITY_EN; reset 0.

## Operation
- rx_serial passes a 2-flop synchronizer to give rx_s. The FSM uses only rx_s.
- The tick counter tcnt, $clog2(OVERSAMPLE) bits, advances only on sample_tick. Clear tcnt on every state entry.
- The bit counter bcnt, $clog2(DATA_BITS+1) bits, counts data bits.
- The armed flag is set whenever rx_s=1. It is cleared on entry to START.
- IDLE: on sample_tick with rx_s=0 and armed=1, go to START.
- START: when tcnt reaches OVERSAMPLE/2−1 on a tick, sample rx_s.
  - If rx_s=1, treat as a glitch: go to IDLE with no output.
  - If rx_s=0, go to DATA.
- DATA: every OVERSAMPLE ticks, sample rx_s into a shift register (LSB first) and increment bcnt.
  - After DATA_BITS samples, go to PARITY if enabled, otherwise to STOP.
- PARITY: after OVERSAMPLE ticks, sample the parity bit, then go to STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s, then go to IDLE.
  - rx_s=1 and parity OK: commit the shift register.
  - rx_s=0: pulse frame_err and discard the byte. A framing error takes precedence over a parity error.
- Commit, rx_valid=0: load rx_data and set rx_valid.
- Commit, rx_valid=1 and rx_ready=1 in the same cycle: load the new byte; rx_valid stays 1; no overrun.
- Commit, rx_valid=1 and rx_ready=0: keep the old byte and pulse overrun_err.
- Handshake without commit: rx_valid=1 and rx_ready=1 clears rx_valid next cycle. rx_data holds its last value.
- A held-low (break) line gives one frame_err. No new frame starts until rx_s returns high, via the armed flag.
- Reset mid-frame: the FSM returns to IDLE, counters clear, the partial byte is dropped, all outputs take their reset values, and the synchronizer flops are set to 1.

## Timing
- Pin to rx_s latency: 2 cycles.
- Data and stop samples occur at bit centre ±1 tick.
- rx_valid rises the cycle after the sys_clk edge whose sample_tick samples the stop bit.
- Error pulses are exactly one sys_clk cycle wide and occur on the same edge that a commit would.
- rx_ready is ignored while rx_valid=0.
- sample_tick has no minimum spacing; a tick on every cycle is legal for simulation.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state exists and even parity is checked.
  - A mismatch pulses parity_err and discards the byte.
  - Frame length is DATA_BITS+3 bits.
- UART_RX_PARITY_EN undefined:
  - The PARITY state, the parity logic and the parity_err port are absent.
  - STOP follows DATA directly.

## Structure
- Package uart_rx_pkg holds:
  - the state enum rx_state_t, with values IDLE, START, DATA, PARITY, STOP;
  - the reset/idle line-level constant.
- Sub-module rx_sync_2ff: 2-flop synchronizer with a parameterized reset value. It is reused for other asynchronous pins.

## Test plan
All cases use OVERSAMPLE=16, DATA_BITS=8 and sample_tick every 4th cycle.
- Frame 0xA5 with correct stop bit, rx_ready=1 → one-cycle rx_valid with rx_data=8'hA5; no error pulses.
- Start-bit glitch: rx_serial low for 5 ticks, then high → stays in IDLE; rx_valid=0; no errors.
- Frame 0x3C with stop bit driven low → frame_err pulses once; rx_valid stays 0. Next frame 0x01 needs the line high first, then gives rx_data=8'h01.
- Frames 0x11 then 0x22 back-to-back, rx_ready=0 → rx_data=8'h11, overrun_err pulses once. Raising rx_ready clears rx_valid the next cycle.
- Parity: with UART_RX_PARITY_EN, frame 0x03 with parity bit 1 → parity_err pulses and no rx_valid. With parity bit 0 → rx_data=8'h03.
- rst_n low for 1 cycle during the 4th data bit → all outputs 0 and FSM in IDLE. A following frame 0x5A is received correctly.
